// File: rtl/alu4_pkg.sv
// Shared definitions for the ALU sequencer: op codes, FSM states, instruction field layout.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package alu4_pkg;

    localparam int OP_W       = 3;
    localparam int DEF_DATA_W = 4;
    localparam int DEF_NREG   = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } seq_state_e;

    // Instruction word, MSB to LSB: imm | op | dst | src_a | src_b.
    function automatic int ins_width(input int aw, input int dw);
        return 1 + OP_W + 2 * aw + dw;
    endfunction

    function automatic int src_a_lsb(input int dw);
        return dw;
    endfunction

    function automatic int dst_lsb(input int aw, input int dw);
        return dw + aw;
    endfunction

    function automatic int op_lsb(input int aw, input int dw);
        return dw + 2 * aw;
    endfunction

    function automatic int imm_bit(input int aw, input int dw);
        return dw + 2 * aw + OP_W;
    endfunction

endpackage

// File: rtl/alu4_regfile.sv
// Register file: NREG x DATA_W, two operand read ports plus a debug read port, one write port.
// Latency: reads combinational, write lands on the rising edge.
// Backpressure: none; the write port is accepted unconditionally.
module alu4_regfile #(
    parameter  int DATA_W = 4,
    parameter  int NREG   = 4,
    localparam int AW     = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     rd_a_addr,
    output logic [DATA_W-1:0] rd_a_data,
    input  logic [AW-1:0]     rd_b_addr,
    output logic [DATA_W-1:0] rd_b_data,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] mem [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_a_data = mem[rd_a_addr];
    assign rd_b_data = mem[rd_b_addr];
    assign dbg_data  = mem[dbg_addr];

endmodule

// File: rtl/alu4_sequencer.sv
// Issue front end for the external 4-bit ALU; ALU4_SEQUENCER_IMM_EN enables immediate operand B.
// Latency: accept at T0, writeback and res_valid at T1, ins_ready back at T2 earliest.
// Backpressure: ins_ready only in IDLE; res_* held stable until res_ready.
module alu4_sequencer
    import alu4_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int NREG   = DEF_NREG,
    localparam int AW     = $clog2(NREG),
    localparam int INS_W  = ins_width(AW, DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ins_valid,
    output logic              ins_ready,
    input  logic [INS_W-1:0]  ins_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_r,
    input  logic              alu_zero,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_zero,
    output logic [AW-1:0]     res_dst,
    input  logic [AW-1:0]     dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int SRCA_LSB = src_a_lsb(DATA_W);
    localparam int DST_LSB  = dst_lsb(AW, DATA_W);
    localparam int OP_LSB   = op_lsb(AW, DATA_W);
    localparam int IMM_BIT  = imm_bit(AW, DATA_W);

    seq_state_e        state;
    logic [AW-1:0]     dst_q;

    logic              f_imm;
    logic [OP_W-1:0]   f_op;
    logic [AW-1:0]     f_dst;
    logic [AW-1:0]     f_src_a;
    logic [DATA_W-1:0] f_src_b;
    logic [AW-1:0]     f_src_b_idx;

    logic [DATA_W-1:0] rd_a_data;
    logic [DATA_W-1:0] rd_b_data;
    logic [DATA_W-1:0] opnd_b;
    logic              wr_en;

    assign f_imm       = ins_data[IMM_BIT];
    assign f_op        = ins_data[OP_LSB +: OP_W];
    assign f_dst       = ins_data[DST_LSB +: AW];
    assign f_src_a     = ins_data[SRCA_LSB +: AW];
    assign f_src_b     = ins_data[DATA_W-1:0];
    assign f_src_b_idx = f_src_b[AW-1:0];

`ifdef ALU4_SEQUENCER_IMM_EN
    assign opnd_b = f_imm ? f_src_b : rd_b_data;
`else
    // imm bit and the upper src_b bits carry no meaning in this build.
    logic unused_ins_bits;
    assign unused_ins_bits = ^{f_imm, f_src_b};
    assign opnd_b          = rd_b_data;
`endif

    // Writeback happens on the ISSUE edge, after the ALU has settled on the registered operands.
    assign wr_en     = (state == ST_ISSUE);
    assign ins_ready = (state == ST_IDLE);

    alu4_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_a_addr (f_src_a),
        .rd_a_data (rd_a_data),
        .rd_b_addr (f_src_b_idx),
        .rd_b_data (rd_b_data),
        .dbg_addr  (dbg_sel),
        .dbg_data  (dbg_data),
        .wr_en     (wr_en),
        .wr_addr   (dst_q),
        .wr_data   (alu_r)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            dst_q     <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_zero  <= 1'b0;
            res_dst   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ins_valid) begin
                        alu_a  <= rd_a_data;
                        alu_b  <= opnd_b;
                        alu_op <= f_op;
                        dst_q  <= f_dst;
                        state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    res_data  <= alu_r;
                    res_zero  <= alu_zero;
                    res_dst   <= dst_q;
                    res_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu4_sequencer.sv
// Bench for alu4_sequencer with a behavioural ALU stand-in and a transaction-level model.
module tb_alu4_sequencer;

    localparam int DATA_W = 4;
    localparam int NREG   = 4;
    localparam int AW     = 2;
    localparam int INS_W  = 4 + 2 * AW + DATA_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ins_valid = 1'b0;
    logic              ins_ready;
    logic [INS_W-1:0]  ins_data = '0;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [2:0]        alu_op;
    logic [DATA_W-1:0] alu_r;
    logic              alu_zero;
    logic              res_valid;
    logic              res_ready = 1'b1;
    logic [DATA_W-1:0] res_data;
    logic              res_zero;
    logic [AW-1:0]     res_dst;
    logic [AW-1:0]     dbg_sel = '0;
    logic [DATA_W-1:0] dbg_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu4_sequencer #(.DATA_W(DATA_W), .NREG(NREG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ins_valid (ins_valid),
        .ins_ready (ins_ready),
        .ins_data  (ins_data),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_r     (alu_r),
        .alu_zero  (alu_zero),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_zero  (res_zero),
        .res_dst   (res_dst),
        .dbg_sel   (dbg_sel),
        .dbg_data  (dbg_data)
    );

    // 4-bit ALU behaviour in plain integer arithmetic.
    function automatic int alu_f(input int op, input int a, input int b);
        case (op)
            0: return (a + b) % 16;
            1: return (a - b + 16) % 16;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return 15 - a;
            6: return (a * 2) % 16;
            default: return a / 2;
        endcase
    endfunction

    always_comb begin
        alu_r    = 4'(alu_f(int'(alu_op), int'(alu_a), int'(alu_b)));
        alu_zero = (alu_r == 4'd0);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one instruction in flight, writeback one edge after accept, retire on res_ready.
    int mregs [NREG];
    bit out = 1'b0;
    int age = 0;
    int n_acc = 0;
    int e_a, e_b, e_op, e_r, e_dst;
    bit e_z;

    always @(posedge clk) begin
        bit was_out;
        if (!rst_n) begin
            out = 1'b0;
            age = 0;
            for (int i = 0; i < NREG; i++) mregs[i] = 0;
        end else begin
            was_out = out;
            if (out && age == 0) begin
                mregs[e_dst] = e_r;
                age = 1;
            end else if (out && res_ready) begin
                out = 1'b0;
            end
            if (!was_out && ins_valid) begin
                e_op  = int'(ins_data[10:8]);
                e_dst = int'(ins_data[7:6]);
                e_a   = mregs[int'(ins_data[5:4])];
`ifdef ALU4_SEQUENCER_IMM_EN
                e_b   = ins_data[11] ? int'(ins_data[3:0]) : mregs[int'(ins_data[1:0])];
`else
                e_b   = mregs[int'(ins_data[1:0])];
`endif
                e_r   = alu_f(e_op, e_a, e_b);
                e_z   = (e_r == 0);
                out   = 1'b1;
                age   = 0;
                n_acc++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("ins_ready", int'(ins_ready), int'(!out));
            if (!out) begin
                chk("res_valid_idle", int'(res_valid), 0);
            end else if (age == 0) begin
                chk("res_valid_issue", int'(res_valid), 0);
                chk("alu_a", int'(alu_a), e_a);
                chk("alu_b", int'(alu_b), e_b);
                chk("alu_op", int'(alu_op), e_op);
            end else begin
                chk("res_valid_resp", int'(res_valid), 1);
                chk("res_data", int'(res_data), e_r);
                chk("res_zero", int'(res_zero), int'(e_z));
                chk("res_dst", int'(res_dst), e_dst);
            end
            chk("dbg_data", int'(dbg_data), mregs[int'(dbg_sel)]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic imm, input logic [2:0] op, input logic [1:0] dst,
                        input logic [1:0] sa, input logic [3:0] sb);
        int start;
        int n;
        start     = n_acc;
        n         = 0;
        ins_data  = {imm, op, dst, sa, sb};
        ins_valid = 1'b1;
        while (n_acc == start && n < 20) begin
            tick();
            n++;
        end
        chk("accept_timeout", int'(n_acc != start), 1);
        ins_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (out && n < 20) begin
            tick();
            n++;
        end
        chk("retire_timeout", int'(out), 0);
    endtask

    task automatic run(input logic imm, input logic [2:0] op, input logic [1:0] dst,
                       input logic [1:0] sa, input logic [3:0] sb);
        send(imm, op, dst, sa, sb);
        wait_done();
    endtask

    task automatic lit_dbg(input string name, input logic [1:0] sel, input int exp);
        dbg_sel = sel;
        #1;
        chk(name, int'(dbg_data), exp);
    endtask

    initial begin
        int n;
        int start;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < NREG; i++) begin
            lit_dbg("reset_dbg", 2'(i), 0);
        end
        chk("reset_ins_ready", int'(ins_ready), 1);
        chk("reset_res_valid", int'(res_valid), 0);
        tick();

`ifdef ALU4_SEQUENCER_IMM_EN
        run(1'b1, 3'd0, 2'd1, 2'd0, 4'd5);
        chk("lit_add_imm5", int'(res_data), 5);
        chk("lit_add_imm5_z", int'(res_zero), 0);
        run(1'b1, 3'd0, 2'd2, 2'd1, 4'd12);
        chk("lit_add_wrap", int'(res_data), 1);
        chk("lit_add_wrap_z", int'(res_zero), 0);
        lit_dbg("lit_dbg_r2", 2'd2, 1);
        run(1'b0, 3'd1, 2'd3, 2'd1, 4'd1);
        chk("lit_sub_zero", int'(res_data), 0);
        chk("lit_sub_zero_z", int'(res_zero), 1);
        chk("lit_sub_dst", int'(res_dst), 3);
        run(1'b0, 3'd0, 2'd0, 2'd1, 4'd2);
        chk("lit_add_reg", int'(res_data), 6);
`else
        run(1'b0, 3'd5, 2'd1, 2'd0, 4'd0);
        chk("lit_not_r0", int'(res_data), 15);
        chk("lit_not_r0_z", int'(res_zero), 0);
        run(1'b0, 3'd0, 2'd2, 2'd1, 4'd1);
        chk("lit_add_wrap", int'(res_data), 14);
        lit_dbg("lit_dbg_r2", 2'd2, 14);
        run(1'b0, 3'd1, 2'd3, 2'd1, 4'd1);
        chk("lit_sub_zero", int'(res_data), 0);
        chk("lit_sub_zero_z", int'(res_zero), 1);
        chk("lit_sub_dst", int'(res_dst), 3);
        run(1'b1, 3'd0, 2'd0, 2'd1, 4'b0010);
        chk("lit_imm_ignored", int'(res_data), 13);
        lit_dbg("lit_dbg_r0", 2'd0, 13);
`endif

        // Result backpressure with a second instruction waiting.
        res_ready = 1'b0;
        send(1'b0, 3'd3, 2'd0, 2'd1, 4'd2);
        ins_data  = {1'b0, 3'd6, 2'd3, 2'd1, 4'd1};
        ins_valid = 1'b1;
        repeat (5) tick();
        chk("hold_ins_ready", int'(ins_ready), 0);
        chk("hold_res_valid", int'(res_valid), 1);
`ifdef ALU4_SEQUENCER_IMM_EN
        chk("lit_hold_or", int'(res_data), 5);
`else
        chk("lit_hold_or", int'(res_data), 15);
`endif
        res_ready = 1'b1;
        start = n_acc;
        n = 0;
        while (n_acc == start && n < 20) begin
            tick();
            n++;
        end
        chk("hold_accept_lat", n, 2);
        ins_valid = 1'b0;
        wait_done();
`ifdef ALU4_SEQUENCER_IMM_EN
        chk("lit_shl", int'(res_data), 10);
`else
        chk("lit_shl", int'(res_data), 14);
`endif

        // Reset while the XOR is in ISSUE: writeback must be lost.
        start = n_acc;
`ifdef ALU4_SEQUENCER_IMM_EN
        ins_data = {1'b1, 3'd4, 2'd1, 2'd1, 4'hF};
`else
        ins_data = {1'b0, 3'd4, 2'd1, 2'd1, 4'd2};
`endif
        ins_valid = 1'b1;
        tick();
        ins_valid = 1'b0;
        chk("xor_accepted", n_acc - start, 1);
        #2 rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        lit_dbg("lit_rst_r1", 2'd1, 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_ins_ready", int'(ins_ready), 1);
        tick();
        chk("rst_res_valid_later", int'(res_valid), 0);

        run(1'b0, 3'd5, 2'd2, 2'd0, 4'd0);
        chk("lit_not_after_rst", int'(res_data), 15);
        run(1'b0, 3'd7, 2'd3, 2'd2, 4'd0);
        chk("lit_shr", int'(res_data), 7);
        lit_dbg("lit_dbg_r3", 2'd3, 7);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
